// File: rtl/sram_arbiter.sv
// Four-port arbiter in front of the single SRAM controller port: port 0 has fixed priority,
// ports 1-3 round-robin, and a starvation guard forces a low-priority grant after a run of port-0 grants.
module sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk_sram,
    input  logic        rst_n_sram,
    input  logic [3:0]  p_req,
    input  logic [3:0]  p_we,
    input  logic [23:0] p_addr      [4],
    input  logic [31:0] p_wdata     [4],
    input  logic [7:0]  p_burst_len [4],
    output logic [3:0]  p_ready,
    output logic [3:0]  p_ack,
    output logic [31:0] p_rdata,
    output logic [15:0] p_burst_rdata,
    output logic [3:0]  p_burst_valid,
    output logic        m_req,
    output logic        m_we,
    output logic [23:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [7:0]  m_burst_len,
    input  logic [31:0] m_rdata,
    input  logic [15:0] m_burst_rdata,
    input  logic        m_ack,
    input  logic        m_ready,
    input  logic        m_burst_valid
);

    typedef enum logic [1:0] {IDLE, GRANT, ACTIVE} state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [23:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [7:0]  m_burst_len_q, m_burst_len_d;
    logic [3:0]  p_ack_q, p_ack_d;

    logic        low_pend;
    logic        starve_hit;
    logic [1:0]  rr_win;
    logic [1:0]  win;

    // Scans lowest priority first so the candidate nearest the pointer overwrites the rest.
    function automatic logic [1:0] rr_pick(input logic [3:1] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [2:0] slot;
        pick = ptr;
        for (int k = 2; k >= 0; k--) begin
            slot = {1'b0, ptr} + 3'(k);
            if (slot > 3'd3) slot = slot - 3'd3;
            if (req[slot[1:0]]) pick = slot[1:0];
        end
        return pick;
    endfunction

    always_comb begin
        low_pend   = |p_req[3:1];
        starve_hit = (starve_cnt_q == STARVE_MAX) && low_pend;
        rr_win     = rr_pick(p_req[3:1], rr_ptr_q);
        win        = (p_req[0] && !starve_hit) ? 2'd0 : rr_win;
    end

    // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        starve_cnt_d  = starve_cnt_q;
        m_req_d       = m_req_q;
        m_we_d        = m_we_q;
        m_addr_d      = m_addr_q;
        m_wdata_d     = m_wdata_q;
        m_burst_len_d = m_burst_len_q;
        p_ack_d       = 4'b0000;

        unique case (state_q)
            IDLE: begin
                if (m_ready && (|p_req)) begin
                    grant_d       = win;
                    m_we_d        = p_we[win] && (p_burst_len[win] == 8'd0);
                    m_addr_d      = p_addr[win];
                    m_wdata_d     = p_wdata[win];
                    m_burst_len_d = p_burst_len[win];
                    state_d       = GRANT;
                    if (win == 2'd0) begin
                        if (!low_pend)                        starve_cnt_d = 8'd0;
                        else if (starve_cnt_q != STARVE_MAX)  starve_cnt_d = starve_cnt_q + 8'd1;
                    end else begin
                        starve_cnt_d = 8'd0;
                        rr_ptr_d     = (win == 2'd3) ? 2'd1 : win + 2'd1;
                    end
                end
            end
            GRANT: begin
                m_req_d = 1'b1;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (m_ack) begin
                    m_req_d           = 1'b0;
                    m_burst_len_d     = 8'd0;
                    p_ack_d[grant_q]  = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_sram or negedge rst_n_sram) begin
        if (!rst_n_sram) begin
            state_q       <= IDLE;
            grant_q       <= 2'd0;
            rr_ptr_q      <= 2'd1;
            starve_cnt_q  <= 8'd0;
            m_req_q       <= 1'b0;
            m_we_q        <= 1'b0;
            m_addr_q      <= 24'd0;
            m_wdata_q     <= 32'd0;
            m_burst_len_q <= 8'd0;
            p_ack_q       <= 4'b0000;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            starve_cnt_q  <= starve_cnt_d;
            m_req_q       <= m_req_d;
            m_we_q        <= m_we_d;
            m_addr_q      <= m_addr_d;
            m_wdata_q     <= m_wdata_d;
            m_burst_len_q <= m_burst_len_d;
            p_ack_q       <= p_ack_d;
        end
    end

    assign m_req         = m_req_q;
    assign m_we          = m_we_q;
    assign m_addr        = m_addr_q;
    assign m_wdata       = m_wdata_q;
    assign m_burst_len   = m_burst_len_q;
    assign p_ack         = p_ack_q;
    assign p_ready       = {4{(state_q == IDLE) && m_ready}};
    assign p_rdata       = m_rdata;
    assign p_burst_rdata = m_burst_rdata;
    // Beats outside ACTIVE belong to nobody and are dropped.
    assign p_burst_valid = (state_q == ACTIVE && m_burst_valid) ? (4'b0001 << grant_q) : 4'b0000;

endmodule
